// File: rtl/mdu_pkg.sv
// Shared constants, mdop bit positions and FSM encoding for the multiply/divide unit.
package mdu_pkg;

    localparam int XLEN = 32;
    localparam int ITER = 32;

    localparam int MDOP_MULT  = 5;
    localparam int MDOP_MULTU = 4;
    localparam int MDOP_DIV   = 3;
    localparam int MDOP_DIVU  = 2;
    localparam int MDOP_MTHI  = 1;
    localparam int MDOP_MTLO  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
module mdu_step
    import mdu_pkg::*;
(
    input  logic              is_div_i,
    input  logic [2*XLEN:0]   acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN:0]   acc_o
);

    logic [XLEN:0]   mul_upper;
    logic [XLEN:0]   rem_shift;
    logic            rem_ge;
    logic [XLEN-1:0] rem_diff;

    // Multiply layout {carry, hi, multiplier}; divide layout {0, remainder, dividend/quotient}.
    always_comb begin
        mul_upper = acc_i[2*XLEN:XLEN];
        if (acc_i[0]) begin
            mul_upper = acc_i[2*XLEN:XLEN] + {1'b0, opnd_i};
        end
        rem_shift = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
        rem_ge    = (rem_shift >= {1'b0, opnd_i});
        rem_diff  = rem_shift[XLEN-1:0] - opnd_i;

        if (!is_div_i) begin
            acc_o = {1'b0, mul_upper, acc_i[XLEN-1:1]};
        end else if (rem_ge) begin
            acc_o = {1'b0, rem_diff, acc_i[XLEN-2:0], 1'b1};
        end else begin
            acc_o = {1'b0, rem_shift[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO; valid/ready request, flushable.
module mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] scr0,
    input  logic [XLEN-1:0] scr1,
    input  logic [5:0]      mdop,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    import mdu_pkg::*;

    // A request transfers on an edge where in_valid & in_ready & ~flush; in_ready is high only in IDLE.
    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2*XLEN:0]   acc_q, acc_d, step_acc;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              is_div_q, is_div_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic              dbz_q, dbz_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              done_q, done_d;

    logic              op_mul, op_div, op_signed, op_mthi, op_mtlo;
    logic              accept, start_arith;
    logic [XLEN-1:0]   mag0, mag1;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;

    always_comb begin
        op_mul    = 1'b0;
        op_div    = 1'b0;
        op_signed = 1'b0;
        op_mthi   = 1'b0;
        op_mtlo   = 1'b0;
        if (mdop[MDOP_MULT]) begin
            op_mul    = 1'b1;
            op_signed = 1'b1;
        end else if (mdop[MDOP_MULTU]) begin
            op_mul = 1'b1;
        end else if (mdop[MDOP_DIV]) begin
            op_div    = 1'b1;
            op_signed = 1'b1;
        end else if (mdop[MDOP_DIVU]) begin
            op_div = 1'b1;
        end else if (mdop[MDOP_MTHI]) begin
            op_mthi = 1'b1;
        end else if (mdop[MDOP_MTLO]) begin
            op_mtlo = 1'b1;
        end
    end

    assign accept      = in_valid & in_ready & ~flush;
    assign start_arith = accept & (op_mul | op_div);
    assign mag0        = (op_signed & scr0[XLEN-1]) ? -scr0 : scr0;
    assign mag1        = (op_signed & scr1[XLEN-1]) ? -scr1 : scr1;

    mdu_step u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_arith) state_d = CALC;
            CALC:    if (flush) state_d = IDLE;
                     else if (cnt_q == 5'(ITER - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = (state_q == IDLE);
        busy     = (state_q != IDLE);
        done     = done_q;
    end

    // Signed divide by zero falls out of the remainder sign fix as HI = scr0; only LO needs forcing.
    always_comb begin
        prod_fix = neg_res_q ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
        quot_fix = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        if (dbz_q) quot_fix = '1;
        rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end

    always_comb begin
        cnt_d     = 5'd0;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = (state_q == FIX) & ~flush;
        case (state_q)
            IDLE: begin
                if (start_arith) begin
                    is_div_d  = op_div;
                    neg_res_d = op_signed & (scr0[XLEN-1] ^ scr1[XLEN-1]);
                    neg_rem_d = op_signed & op_div & scr0[XLEN-1];
                    dbz_d     = op_div & (scr1 == '0);
                    acc_d     = {{(XLEN+1){1'b0}}, op_div ? mag0 : mag1};
                    opnd_d    = op_div ? mag1 : mag0;
                end else if (accept & op_mthi) begin
                    hi_d = scr0;
                end else if (accept & op_mtlo) begin
                    lo_d = scr0;
                end
            end
            CALC: begin
                if (!flush) begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            FIX: begin
                if (!flush) begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[2*XLEN-1:XLEN];
                        lo_d = prod_fix[XLEN-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= 5'd0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
